alu_share_arbiter: RTL and testbench

//  Shares one combinational alu instance between NREQ requesters (e.g. main execute path, branch unit, AGU).

---
 rtl/alu_share_arbiter_pkg.sv | 24 ++
 rtl/alu_share_arbiter_rr_pick.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// =============================================================================
//  Module   : alu_share_arbiter_pkg
//  Brief    : FSM state encoding and ALUOp codes shared by the arbiter and bench
//  Revision : 1.0  initial release
// =============================================================================
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [4:0] c_aluop_nop   = 5'd0;
    localparam logic [4:0] c_aluop_add   = 5'd1;
    localparam logic [4:0] c_aluop_sub   = 5'd2;
    localparam logic [4:0] c_aluop_and   = 5'd3;
    localparam logic [4:0] c_aluop_or    = 5'd4;
    localparam logic [4:0] c_aluop_xor   = 5'd5;
    localparam logic [4:0] c_aluop_auipc = 5'd6;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_pick.sv
`default_nettype none
// =============================================================================
//  Module   : alu_share_arbiter_rr_pick
//  Brief    : Combinational rotating picker: first request at or after ptr wins
//  Revision : 1.0  initial release
// =============================================================================
module alu_share_arbiter_rr_pick #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_grant_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_rot;
    logic [PW:0]     w_sum;

    // w_rot[k] is request (ptr + k) mod NREQ
    assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_sum = '0;
        o_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = {1'b0, i_ptr} + (PW+1)'(i);
                o_any = 1'b1;
            end
        end
        if (w_sum >= (PW+1)'(NREQ)) begin
            w_sum = w_sum - (PW+1)'(NREQ);
        end
    end

    assign o_grant_idx = w_sum[PW-1:0];

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = o_any && (o_grant_idx == PW'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// =============================================================================
//  Module   : alu_share_arbiter
//  Brief    : Shares one combinational ALU between NREQ valid/ready requesters.
//             Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
//  Revision : 1.0  initial release
// =============================================================================
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    input  logic [NREQ*OPW-1:0]  req_op,
    input  logic [NREQ*XLEN-1:0] req_pc,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_c,
    output logic                 rsp_zero,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [XLEN-1:0]      alu_pc,
    output logic [OPW-1:0]       alu_op,
    input  logic [XLEN-1:0]      alu_c,
    input  logic                 alu_zero
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    logic [XLEN-1:0] r_a, r_b, r_pc, r_rsp_c;
    logic [OPW-1:0]  r_op;
    logic [NREQ-1:0] r_gnt, r_rsp_valid;
    logic            r_rsp_zero;

    logic [PW-1:0]   w_ptr, w_gnt_idx;
    logic [NREQ-1:0] w_gnt;
    logic            w_any;
    logic [XLEN-1:0] w_sel_a, w_sel_b, w_sel_pc;
    logic [OPW-1:0]  w_sel_op;

    alu_share_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req       (req_valid),
        .i_ptr       (w_ptr),
        .o_grant     (w_gnt),
        .o_grant_idx (w_gnt_idx),
        .o_any       (w_any)
    );

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_pc = '0;
        w_sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a  = req_a[i*XLEN +: XLEN];
                w_sel_b  = req_b[i*XLEN +: XLEN];
                w_sel_pc = req_pc[i*XLEN +: XLEN];
                w_sel_op = req_op[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_pc        <= '0;
            r_op        <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_c     <= '0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_pc    <= w_sel_pc;
                        r_op    <= w_sel_op;
                        r_gnt   <= w_gnt;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_c     <= alu_c;
                    r_rsp_zero  <= alu_zero;
                    r_rsp_valid <= r_gnt;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // only the owner's ready bit completes the handshake
                    if (|(rsp_ready & r_rsp_valid)) begin
                        r_rsp_valid <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE && !rst) ? w_gnt : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_c     = r_rsp_c;
    assign rsp_zero  = r_rsp_zero;

    // operand registers only move on accept, so the alu sees stable inputs
    assign alu_a  = r_a;
    assign alu_b  = r_b;
    assign alu_pc = r_pc;
    assign alu_op = r_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// =============================================================================
//  Module   : tb_alu_share_arbiter
//  Brief    : Self-checking bench with a transaction-level reference model
//  Revision : 1.0  initial release
// =============================================================================
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int OPW  = 5;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*XLEN-1:0] req_a, req_b, req_pc;
    logic [NREQ*OPW-1:0]  req_op;
    logic [XLEN-1:0]      rsp_c, alu_a, alu_b, alu_pc, alu_c;
    logic                 rsp_zero, alu_zero;
    logic [OPW-1:0]       alu_op;

    alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                               input logic [OPW-1:0] op, input logic [XLEN-1:0] pc);
        case (op)
            c_aluop_add:   return a + b;
            c_aluop_sub:   return a - b;
            c_aluop_and:   return a & b;
            c_aluop_or:    return a | b;
            c_aluop_xor:   return a ^ b;
            c_aluop_auipc: return pc + b;
            default:       return '0;
        endcase
    endfunction

    assign alu_c    = alu_f(alu_a, alu_b, alu_op, alu_pc);
    assign alu_zero = (alu_c == '0);

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // arbitration rule expressed directly: first valid requester at or after ptr
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`else
        for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    // transaction model: busy flag plus cycles since accept
    bit              m_busy  = 0;
    int              m_age   = 0;
    int              m_owner = 0;
    int              m_ptr   = 0;
    logic [XLEN-1:0] m_a = '0, m_b = '0, m_pc = '0, m_c = '0;
    logic [OPW-1:0]  m_op = '0;
    logic            m_zero = 1'b0;
    int              dg[$];
    int              dcyc[$];
    int              cyc = 0;

    initial begin
        @(posedge clk);
        forever begin
            int w;
            logic [NREQ-1:0] e_ready, e_rv;
            @(negedge clk);
            cyc++;
            w       = (!rst && !m_busy) ? pick(req_valid, m_ptr) : -1;
            e_ready = (w >= 0) ? NREQ'(1 << w) : '0;
            e_rv    = (m_busy && m_age >= 2) ? NREQ'(1 << m_owner) : '0;
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("rsp_c", 64'(rsp_c), 64'(m_c));
            chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
            chk("alu_a", 64'(alu_a), 64'(m_a));
            chk("alu_b", 64'(alu_b), 64'(m_b));
            chk("alu_pc", 64'(alu_pc), 64'(m_pc));
            chk("alu_op", 64'(alu_op), 64'(m_op));
            if (req_ready != '0) begin
                dg.push_back(onehot_idx(req_ready));
                dcyc.push_back(cyc);
            end
            if (rst) begin
                m_busy = 0; m_age = 0; m_ptr = 0;
                m_a = '0; m_b = '0; m_pc = '0; m_op = '0; m_c = '0; m_zero = 1'b0;
            end else if (w >= 0) begin
                m_busy  = 1;
                m_age   = 1;
                m_owner = w;
                m_a     = req_a[w*XLEN +: XLEN];
                m_b     = req_b[w*XLEN +: XLEN];
                m_pc    = req_pc[w*XLEN +: XLEN];
                m_op    = req_op[w*OPW +: OPW];
                m_ptr   = (w + 1) % NREQ;
            end else if (m_busy && m_age == 1) begin
                m_age  = 2;
                m_c    = alu_f(m_a, m_b, m_op, m_pc);
                m_zero = (m_c == '0);
            end else if (m_busy && rsp_ready[m_owner]) begin
                m_busy = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [OPW-1:0] op, input logic [XLEN-1:0] pc);
        req_a[i*XLEN +: XLEN]  = a;
        req_b[i*XLEN +: XLEN]  = b;
        req_op[i*OPW +: OPW]   = op;
        req_pc[i*XLEN +: XLEN] = pc;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0; rsp_ready = '1;
        repeat (4) step();
        rsp_ready = '0;
    endtask

    logic [OPW-1:0] ops[6];
    int t2_exp[4];
    int k;

    initial begin
        ops[0] = c_aluop_add; ops[1] = c_aluop_sub; ops[2] = c_aluop_and;
        ops[3] = c_aluop_or;  ops[4] = c_aluop_xor; ops[5] = c_aluop_auipc;
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0; req_pc = '0;
        step(); step();

        // test 1: reset state, then a single add
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_c", 64'(rsp_c), 64'h0);
        chk("rst_alu_a", 64'(alu_a), 64'h0);
        chk("rst_alu_op", 64'(alu_op), 64'h0);
        step();
        rst = 1'b0;
        set_req(0, 32'd5, 32'd3, c_aluop_add, 32'd0);
        req_valid = 3'b001;
        @(negedge clk);
        chk("t1_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_exec_rv", 64'(rsp_valid), 64'h0);
        step();
        @(negedge clk);
        chk("t1_rv", 64'(rsp_valid), 64'h1);
        chk("t1_c", 64'(rsp_c), 64'd8);
        chk("t1_zero", 64'(rsp_zero), 64'h0);
        step();
        drain();

        // test 2: two requesters held continuously
        do_reset();
        set_req(0, 32'd10, 32'd1, c_aluop_add, 32'd0);
        set_req(1, 32'd20, 32'd2, c_aluop_sub, 32'd0);
        req_valid = 3'b011; rsp_ready = 3'b011;
        dg.delete(); dcyc.delete();
        repeat (13) step();
`ifdef ALU_ARB_FIXED_PRIO_EN
        t2_exp = '{0, 0, 0, 0};
`else
        t2_exp = '{0, 1, 0, 1};
`endif
        chk("t2_count", 64'(dg.size() >= 4), 64'h1);
        if (dg.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t2_grant", 64'(dg[i]), 64'(t2_exp[i]));
            for (int i = 1; i < 4; i++) chk("t2_interval", 64'(dcyc[i] - dcyc[i-1]), 64'd3);
        end
        drain();

        // test 3: response held stable under backpressure
        set_req(0, 32'd7, 32'd7, c_aluop_sub, 32'd0);
        req_valid = 3'b001;
        @(negedge clk);
        chk("t3_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 3'b011;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_rv", 64'(rsp_valid), 64'h1);
            chk("t3_c", 64'(rsp_c), 64'h0);
            chk("t3_zero", 64'(rsp_zero), 64'h1);
            chk("t3_ready_low", 64'(req_ready), 64'h0);
            step();
        end
        req_valid = '0; rsp_ready = 3'b001;
        step();
        drain();

        // test 4: auipc, operands changed after accept
        set_req(1, 32'h55, 32'h20, c_aluop_auipc, 32'h1000);
        req_valid = 3'b010; rsp_ready = '1;
        step();
        set_req(1, 32'hdead, 32'h20, c_aluop_auipc, 32'h7777);
        req_valid = '0;
        k = 0;
        @(negedge clk);
        while (rsp_valid !== 3'b010 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t4_timeout", 64'(k < 10), 64'h1);
        chk("t4_c", 64'(rsp_c), 64'h1020);
        step();
        drain();

        // test 5: reset during EXEC
        set_req(0, 32'd1, 32'd1, c_aluop_add, 32'd0);
        req_valid = 3'b001;
        step();
        rst = 1'b1; req_valid = '0;
        step();
        rst = 1'b0;
        set_req(1, 32'd4, 32'd4, c_aluop_xor, 32'd0);
        req_valid = 3'b010;
        @(negedge clk);
        chk("t5_rv", 64'(rsp_valid), 64'h0);
        chk("t5_ready", 64'(req_ready), 64'h2);
        step();
        drain();

        // random phase
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic [XLEN-1:0] a;
                a = $urandom;
                set_req(i, a, ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom),
                        ops[$urandom_range(0, 5)], XLEN'($urandom));
            end
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            rst       = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
